imm_extend_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the RISC-V decode path.

---
 rtl/imm_extend_pipe.sv | 118 +++++++++++
 tb/tb_imm_extend_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate generator for the RISC-V decode path.
// S1 holds the raw request; S2 holds the extended immediate and drives the outputs.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  logic             s1Valid;
  logic [31:0]      s1Instr;
  logic [2:0]       s1ImmSrc;
  logic [TAG_W-1:0] s1Tag;
  logic             adv1;
  logic             adv2;
  logic             inAccept;
  logic [5:0]       shamt;
  logic [31:0]      imm32;
  logic             immErr;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1Valid || adv2;
  assign in_ready = adv1;
  assign inAccept = in_valid && adv1;

  // Shift-amount field width depends on XLEN (6 bits for RV64, 5 for RV32).
  always_comb begin
    shamt = 6'd0;
    if (XLEN == 64) begin
      shamt = s1Instr[25:20];
    end else begin
      shamt = {1'b0, s1Instr[24:20]};
    end
  end

  // Every format is built as a 32-bit value whose bit 31 is the correct
  // extension bit, so the final widening to XLEN is always a sign extension.
  always_comb begin
    imm32  = 32'd0;
    immErr = 1'b0;
    case (s1ImmSrc)
      3'b000: imm32 = {{20{s1Instr[31]}}, s1Instr[31:20]};
      3'b001: imm32 = {{20{s1Instr[31]}}, s1Instr[31:25], s1Instr[11:7]};
      3'b010: imm32 = {{19{s1Instr[31]}}, s1Instr[31], s1Instr[7],
                       s1Instr[30:25], s1Instr[11:8], 1'b0};
      3'b011: imm32 = {{11{s1Instr[31]}}, s1Instr[31], s1Instr[19:12],
                       s1Instr[20], s1Instr[30:21], 1'b0};
      3'b100: imm32 = {s1Instr[31:12], 12'd0};
      3'b101: imm32 = {27'd0, s1Instr[19:15]};
      3'b110: imm32 = {26'd0, shamt};
      3'b111: begin
        imm32  = 32'd0;
        immErr = 1'b1;
      end
      default: begin
        imm32  = 32'd0;
        immErr = 1'b1;
      end
    endcase
  end

  // Stage 1: capture the request whenever the stage is free or draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid  <= 1'b0;
      s1Instr  <= 32'd0;
      s1ImmSrc <= 3'd0;
      s1Tag    <= '0;
    end else if (adv1) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Instr  <= Instr;
        s1ImmSrc <= ImmSrc;
        s1Tag    <= in_tag;
      end
    end
  end

  // Stage 2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ImmExt    <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        ImmExt  <= XLEN'($signed(imm32));
        out_tag <= s1Tag;
        out_err <= immErr;
      end
    end
  end

  // Illegal requests are counted at acceptance, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (inAccept && (ImmSrc == 3'b111) && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32, XLEN=64 and CNT_W=2 instances share one stimulus.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [31:0] instr;
  logic [2:0]  immSrc;
  logic [3:0]  inTag;
  logic        outReady;

  logic        inReady32, outValid32, outErr32;
  logic [31:0] immExt32;
  logic [3:0]  outTag32;
  logic [15:0] errCount32;

  logic        inReady64, outValid64, outErr64;
  logic [63:0] immExt64;
  logic [3:0]  outTag64;
  logic [15:0] errCount64;

  logic        inReadyC2, outValidC2, outErrC2;
  logic [31:0] immExtC2;
  logic [3:0]  outTagC2;
  logic [1:0]  errCountC2;

  int passCount = 0;
  int totalCount = 0;

  logic [31:0] vInstr [0:10];
  logic [2:0]  vSrc   [0:10];
  logic [31:0] vExp32 [0:10];
  logic [63:0] vExp64 [0:10];
  logic        vErr   [0:10];

  imm_extend_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady32),
    .Instr(instr), .ImmSrc(immSrc), .in_tag(inTag), .out_valid(outValid32),
    .out_ready(outReady), .ImmExt(immExt32), .out_tag(outTag32),
    .out_err(outErr32), .err_count(errCount32));

  imm_extend_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady64),
    .Instr(instr), .ImmSrc(immSrc), .in_tag(inTag), .out_valid(outValid64),
    .out_ready(outReady), .ImmExt(immExt64), .out_tag(outTag64),
    .out_err(outErr64), .err_count(errCount64));

  imm_extend_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(2)) dutC2 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyC2),
    .Instr(instr), .ImmSrc(immSrc), .in_tag(inTag), .out_valid(outValidC2),
    .out_ready(outReady), .ImmExt(immExtC2), .out_tag(outTagC2),
    .out_err(outErrC2), .err_count(errCountC2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tg);
    inValid = 1'b1;
    instr   = ins;
    immSrc  = src;
    inTag   = tg;
  endtask

  initial begin
    vInstr[0]  = 32'h00C48413; vSrc[0]  = 3'd0; vExp32[0]  = 32'h0000000C; vExp64[0]  = 64'h000000000000000C; vErr[0]  = 1'b0;
    vInstr[1]  = 32'hFFF00093; vSrc[1]  = 3'd0; vExp32[1]  = 32'hFFFFFFFF; vExp64[1]  = 64'hFFFFFFFFFFFFFFFF; vErr[1]  = 1'b0;
    vInstr[2]  = 32'hFE000C23; vSrc[2]  = 3'd1; vExp32[2]  = 32'hFFFFFFF8; vExp64[2]  = 64'hFFFFFFFFFFFFFFF8; vErr[2]  = 1'b0;
    vInstr[3]  = 32'hFE000EE3; vSrc[3]  = 3'd2; vExp32[3]  = 32'hFFFFFFFC; vExp64[3]  = 64'hFFFFFFFFFFFFFFFC; vErr[3]  = 1'b0;
    vInstr[4]  = 32'hFFDFF06F; vSrc[4]  = 3'd3; vExp32[4]  = 32'hFFFFFFFC; vExp64[4]  = 64'hFFFFFFFFFFFFFFFC; vErr[4]  = 1'b0;
    vInstr[5]  = 32'h123450B7; vSrc[5]  = 3'd4; vExp32[5]  = 32'h12345000; vExp64[5]  = 64'h0000000012345000; vErr[5]  = 1'b0;
    vInstr[6]  = 32'h800000B7; vSrc[6]  = 3'd4; vExp32[6]  = 32'h80000000; vExp64[6]  = 64'hFFFFFFFF80000000; vErr[6]  = 1'b0;
    vInstr[7]  = 32'hFFFA8073; vSrc[7]  = 3'd5; vExp32[7]  = 32'h00000015; vExp64[7]  = 64'h0000000000000015; vErr[7]  = 1'b0;
    vInstr[8]  = 32'h02509093; vSrc[8]  = 3'd6; vExp32[8]  = 32'h00000005; vExp64[8]  = 64'h0000000000000025; vErr[8]  = 1'b0;
    vInstr[9]  = 32'h12345678; vSrc[9]  = 3'd7; vExp32[9]  = 32'h00000000; vExp64[9]  = 64'h0000000000000000; vErr[9]  = 1'b1;
    vInstr[10] = 32'hFFFFFFFF; vSrc[10] = 3'd7; vExp32[10] = 32'h00000000; vExp64[10] = 64'h0000000000000000; vErr[10] = 1'b1;

    reset = 1'b1; inValid = 1'b0; instr = 32'd0; immSrc = 3'd0; inTag = 4'd0; outReady = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(outValid32), 64'd0);
    chk("rst_imm", 64'(immExt32), 64'd0);
    chk("rst_tag_err", 64'({outTag32, outErr32}), 64'd0);
    chk("rst_err_count", 64'(errCount32), 64'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(inReady32), 64'd1);

    // Single request: two-register latency
    drive(32'h00C48413, 3'd0, 4'd3);
    step();
    inValid = 1'b0;
    chk("lat_not_early", 64'(outValid32), 64'd0);
    step();
    chk("lat_valid", 64'(outValid32), 64'd1);
    chk("lat_imm", 64'(immExt32), 64'h0000000C);
    chk("lat_tag", 64'(outTag32), 64'd3);
    chk("lat_err", 64'(outErr32), 64'd0);
    step();
    chk("lat_single", 64'(outValid32), 64'd0);

    // Back-to-back stream covering every format at one request per cycle
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) drive(vInstr[i], vSrc[i], 4'(i));
      else inValid = 1'b0;
      step();
      if (i >= 1) begin
        chk($sformatf("b2b_valid_%0d", i - 1), 64'({outValid32, outValid64}), 64'd3);
        chk($sformatf("b2b_imm32_%0d", i - 1), 64'(immExt32), 64'(vExp32[i - 1]));
        chk($sformatf("b2b_imm64_%0d", i - 1), immExt64, vExp64[i - 1]);
        chk($sformatf("b2b_tag_%0d", i - 1), 64'(outTag32), 64'(i - 1));
        chk($sformatf("b2b_err_%0d", i - 1), 64'({outErr32, outErr64}), 64'({vErr[i - 1], vErr[i - 1]}));
      end
    end
    step();
    chk("b2b_drained", 64'(outValid32), 64'd0);
    chk("errcnt_two", 64'(errCount32), 64'd2);
    chk("errcnt_c2_two", 64'(errCountC2), 64'd2);

    // Three more illegal requests: narrow counter saturates
    for (int k = 0; k < 3; k++) begin
      drive(32'hDEADBEEF, 3'd7, 4'd9);
      step();
    end
    inValid = 1'b0;
    step();
    step();
    chk("errcnt_five", 64'(errCount32), 64'd5);
    chk("errcnt64_five", 64'(errCount64), 64'd5);
    chk("errcnt_c2_sat", 64'(errCountC2), 64'd3);

    // Backpressure: five cycles with out_ready low while three requests are offered
    outReady = 1'b0;
    drive(32'h00100013, 3'd0, 4'd10);
    #1 chk("stall_rdy_a", 64'(inReady32), 64'd1);
    step();
    drive(32'h00200013, 3'd0, 4'd11);
    #1 chk("stall_rdy_b", 64'(inReady32), 64'd1);
    step();
    drive(32'h00300013, 3'd0, 4'd12);
    #1 chk("stall_rdy_full", 64'(inReady32), 64'd0);
    chk("stall_head", 64'({outValid32, outTag32}), 64'({1'b1, 4'd10}));
    step();
    chk("stall_hold1", 64'({outValid32, outTag32, immExt32}), 64'({1'b1, 4'd10, 32'd1}));
    chk("stall_rdy_held", 64'(inReady32), 64'd0);
    step();
    step();
    chk("stall_hold3", 64'({outValid32, outTag32, immExt32, outErr32}), 64'({1'b1, 4'd10, 32'd1, 1'b0}));
    outReady = 1'b1;
    #1 chk("stall_rdy_comb", 64'(inReady32), 64'd1);
    step();
    inValid = 1'b0;
    chk("drain_b", 64'({outValid32, outTag32, immExt32}), 64'({1'b1, 4'd11, 32'd2}));
    step();
    chk("drain_c", 64'({outValid32, outTag32, immExt32}), 64'({1'b1, 4'd12, 32'd3}));
    step();
    chk("drain_no_dup", 64'(outValid32), 64'd0);

    // Reset with two requests in flight
    outReady = 1'b0;
    drive(32'h00000000, 3'd7, 4'd1);
    step();
    drive(32'h00500013, 3'd0, 4'd2);
    step();
    inValid = 1'b0;
    chk("inflight_valid", 64'(outValid32), 64'd1);
    chk("inflight_errcnt", 64'(errCount32), 64'd6);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'({outValid32, outValid64}), 64'd0);
    chk("async_rst_errcnt", 64'(errCount32), 64'd0);
    chk("async_rst_rdy", 64'(inReady32), 64'd1);
    step();
    reset = 1'b0;
    outReady = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("no_stale_%0d", j), 64'({outValid32, outValid64}), 64'd0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
